// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock, then sign fix.
// Optional macro DIV_FAST_PATH_EN skips the iterations for divisor 0/+1/-1 and dividend 0.
module booth_seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] dividend,
  input  logic signed [VW-1:0] divisor,
  output logic signed [DW-1:0] quotient,
  output logic signed [VW-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0] dd_r;
  logic signed [VW-1:0] dv_r;
  logic [DW-1:0]        qd;
  logic [VW-1:0]        pr;
  logic [VW:0]          mv;
  logic [CW-1:0]        cnt;
  logic                 sign_q, sign_r;

  logic [DW-1:0]        mag_d;
  logic signed [VW:0]   dv_x;
  logic [VW:0]          mag_v;
  logic [VW:0]          sh;
  logic                 ge;
  logic                 fast;

  always_comb begin
    mag_d = dd_r[DW-1] ? -dd_r : dd_r;
    dv_x  = {dv_r[VW-1], dv_r};
    mag_v = dv_r[VW-1] ? -dv_x : dv_x;
    // pr < |divisor| always, so the shifted partial remainder fits in VW+1 bits
    sh    = {pr, qd[DW-1]};
    ge    = (sh >= mv);
`ifdef DIV_FAST_PATH_EN
    fast  = (dv_r == '0) || (dd_r == '0) || (dv_r == VW'(1)) || (dv_r == '1);
`else
    fast  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: state_nxt = fast ? FIX : ITER;
      ITER: if (cnt == CW'(DW - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dd_r <= dividend;
          dv_r <= divisor;
        end
        PREP: begin
          // the quotient register starts out holding the dividend magnitude and shifts it out MSB-first
          qd     <= mag_d;
          pr     <= '0;
          mv     <= mag_v;
          cnt    <= '0;
          sign_q <= dd_r[DW-1] ^ dv_r[VW-1];
          sign_r <= dd_r[DW-1];
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (ge) begin
            pr <= VW'(sh - mv);
            qd <= {qd[DW-2:0], 1'b1};
          end else begin
            pr <= sh[VW-1:0];
            qd <= {qd[DW-2:0], 1'b0};
          end
        end
        FIX: begin
          div_zero <= (mv == '0);
          ovf      <= (dd_r == {1'b1, {(DW-1){1'b0}}}) && (dv_r == '1);
          if (mv == '0) begin
            quotient  <= '1;
            remainder <= '0;
          end else begin
            quotient  <= sign_q ? -qd : qd;
            remainder <= sign_r ? -pr : pr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed bench for booth_seq_divider: hand vectors, handshake corner cases, reset abort, full operand sweep.
module tb_booth_seq_divider;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic signed [7:0] dividend;
  logic signed [3:0] divisor;
  logic signed [7:0] quotient;
  logic signed [3:0] remainder;
  logic              busy, done, div_zero, ovf;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  booth_seq_divider #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  function automatic int exp_lat(input int a, input int b);
`ifdef DIV_FAST_PATH_EN
    if (a == 0 || b == 0 || b == 1 || b == -1) return 2;
`endif
    return 10;
  endfunction

  // Runs one operation from IDLE, checks results in the DONE cycle, then steps back to IDLE.
  task automatic op_chk(input string tag, input int a, input int b, input int eq, input int er,
                        input int ez, input int eo);
    int cyc;
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done(cyc);
    check({tag, ".lat"}, cyc, exp_lat(a, b));
    check({tag, ".q"}, int'(quotient), eq);
    check({tag, ".r"}, int'(remainder), er);
    check({tag, ".flags"}, {div_zero, ovf}, {ez[0], eo[0]});
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, d0, q, r, z, o;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.q", int'(quotient), 0);
    check("reset.r", int'(remainder), 0);
    check("reset.flags", {div_zero, ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic op, exact latency, then start held during the DONE cycle must be ignored
    dividend = 8'sd100; divisor = 4'sd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("t1.lat", cyc, 10);
    check("t1.q", int'(quotient), 14);
    check("t1.r", int'(remainder), 2);
    check("t1.flags", {div_zero, ovf}, 0);
    dividend = 8'sd3; divisor = 4'sd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t1.done_start_ignored", busy, 0);
    @(posedge clk); #1;
    check("t1.still_idle", busy, 0);
    check("t1.hold_q", int'(quotient), 14);

    op_chk("t2a", -100, 7, -14, -2, 0, 0);
    op_chk("t2b", 100, -7, -14, 2, 0, 0);
    op_chk("t2c", -100, -7, 14, -2, 0, 0);
    op_chk("t3ovf", -128, -1, -128, 0, 0, 1);
    op_chk("t3dz", 5, 0, -1, 0, 1, 0);
    op_chk("t3zero", 0, -3, 0, 0, 0, 0);
    op_chk("t3minv", -128, -8, 16, 0, 0, 0);
    op_chk("t3b", 127, -8, -15, 7, 0, 0);
    op_chk("t3c", -128, 7, -18, -2, 0, 0);
    op_chk("t3d", 1, 5, 0, 1, 0, 0);

    // starts during the op at cycles 3 and 9 must not queue or disturb it
    d0 = done_cnt;
    dividend = 8'sd100; divisor = 4'sd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = -8'sd50; divisor = 4'sd3;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("t4.done_at_10", done, 1);
    check("t4.q", int'(quotient), 14);
    check("t4.r", int'(remainder), 2);
    repeat (12) @(posedge clk);
    #1;
    check("t4.single_done", done_cnt - d0, 1);
    check("t4.idle", busy, 0);

    // reset in the middle of an op abandons it
    op_chk("t5pre", -100, -7, 14, -2, 0, 0);
    d0 = done_cnt;
    dividend = 8'sd100; divisor = 4'sd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("t5.busy", busy, 0);
    check("t5.done", done, 0);
    check("t5.q", int'(quotient), 0);
    check("t5.r", int'(remainder), 0);
    repeat (15) @(posedge clk);
    #1;
    check("t5.no_done", done_cnt - d0, 0);
    op_chk("t5post", 100, 7, 14, 2, 0, 0);

    // full operand sweep against native signed division
    for (int a = -128; a < 128; a++) begin
      for (int b = -8; b < 8; b++) begin
        z = 0; o = 0;
        if (b == 0) begin
          q = -1; r = 0; z = 1;
        end else if (a == -128 && b == -1) begin
          q = -128; r = 0; o = 1;
        end else begin
          q = a / b; r = a % b;
        end
        op_chk("sweep", a, b, q, r, z, o);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
